fb_line_arbiter: RTL and testbench

Arbiter/scheduler for the single-port frame-buffer memory behind the VGA output path. Shares the memory between the display side, which fetches one scan line into the line buffer ahead of scanout, and the frame writer, which loads decoded video frames. Display fetches have absolute priority; the writer gets every cycle not used by a fetch. Sits between the VGA timing generator, the line buffer and the frame loader, all on the 50 MHz domain.

---
 rtl/fb_pkg.sv | 16 +
 rtl/fb_page_ctrl.sv | 42 ++++
 rtl/fb_line_arbiter.sv | 132 +++++++++++++
 tb/tb_fb_line_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and FSM state type for the frame-buffer line arbiter.
// The double-buffer feature is selected by defining FB_DOUBLE_BUFFER_EN.
package fb_pkg;

  localparam int unsigned FB_DATA_W         = 16;
  localparam int unsigned FB_WORDS_PER_LINE = 40;
  localparam int unsigned FB_LINES          = 480;
  localparam int unsigned FB_ADDR_W         = 16;
  localparam int unsigned FB_LINE_W         = 9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_page_ctrl.sv
// Display-page and swap-pending bookkeeping for double buffering.
// Only compiled when FB_DOUBLE_BUFFER_EN is defined.
`ifdef FB_DOUBLE_BUFFER_EN
module fb_page_ctrl (
  input  logic clk_i,
  input  logic reset_i,
  input  logic frame_start_i,
  input  logic wr_frame_done_i,
  output logic disp_page_o,
  output logic swap_pending_o
);

  logic disp_page_q, disp_page_d;
  logic swap_pending_q, swap_pending_d;

  // A finished frame only becomes visible at the next vertical blank.
  always_comb begin
    disp_page_d    = disp_page_q;
    swap_pending_d = swap_pending_q;
    if (frame_start_i && swap_pending_q) begin
      disp_page_d    = ~disp_page_q;
      swap_pending_d = wr_frame_done_i;
    end else if (wr_frame_done_i) begin
      swap_pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      disp_page_q    <= 1'b0;
      swap_pending_q <= 1'b0;
    end else begin
      disp_page_q    <= disp_page_d;
      swap_pending_q <= swap_pending_d;
    end
  end

  assign disp_page_o    = disp_page_q;
  assign swap_pending_o = swap_pending_q;

endmodule
`endif

// File: rtl/fb_line_arbiter.sv
// Frame-buffer memory arbiter: display line fetches pre-empt the frame writer.
// Define FB_DOUBLE_BUFFER_EN for two pages with a swap at vertical blank.
module fb_line_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W         = FB_DATA_W,
  parameter int unsigned WORDS_PER_LINE = FB_WORDS_PER_LINE,
  parameter int unsigned LINES          = FB_LINES,
  parameter int unsigned ADDR_W         = FB_ADDR_W,
  parameter int unsigned LINE_W         = FB_LINE_W
) (
  input  logic                              clk_50,
  input  logic                              reset,
  input  logic                              line_req,
  input  logic [LINE_W-1:0]                 line_idx,
  input  logic                              frame_start,
  output logic                              fetch_done,
  output logic                              lb_we,
  output logic [$clog2(WORDS_PER_LINE)-1:0] lb_addr,
  output logic [DATA_W-1:0]                 lb_data,
  input  logic                              wr_valid,
  output logic                              wr_ready,
  input  logic [ADDR_W-1:0]                 wr_addr,
  input  logic [DATA_W-1:0]                 wr_data,
  input  logic                              wr_frame_done,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic                              mem_we,
  output logic [DATA_W-1:0]                 mem_wdata,
  input  logic [DATA_W-1:0]                 mem_rdata,
  output logic                              overrun,
  output logic                              disp_page
);

  localparam int unsigned       K_W        = $clog2(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] PAGE_WORDS = ADDR_W'(WORDS_PER_LINE * LINES);
  localparam logic [ADDR_W-1:0] LINE_WORDS = ADDR_W'(WORDS_PER_LINE);
  localparam logic [K_W-1:0]    K_LAST     = K_W'(WORDS_PER_LINE - 1);

  fb_state_e         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [K_W-1:0]    k_q, k_d;
  logic              overrun_q, overrun_d;
  logic              lb_we_q, fetch_done_q;
  logic [K_W-1:0]    lb_addr_q;
  logic              swap_pending;
  logic              disp_page_w;
  logic              wr_page;

`ifdef FB_DOUBLE_BUFFER_EN
  fb_page_ctrl u_page_ctrl (
    .clk_i          (clk_50),
    .reset_i        (reset),
    .frame_start_i  (frame_start),
    .wr_frame_done_i(wr_frame_done),
    .disp_page_o    (disp_page_w),
    .swap_pending_o (swap_pending)
  );
  assign wr_page = ~disp_page_w;
`else
  // Single page: the writer updates the very page being scanned out.
  logic unused_page_inputs;
  assign unused_page_inputs = frame_start ^ wr_frame_done;
  assign disp_page_w        = 1'b0;
  assign swap_pending       = 1'b0;
  assign wr_page            = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    k_d       = k_q;
    overrun_d = overrun_q;
    wr_ready  = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        wr_ready = !line_req && !swap_pending;
        if (line_req) begin
          base_d  = (disp_page_w ? PAGE_WORDS : '0) + ADDR_W'(line_idx) * LINE_WORDS;
          k_d     = '0;
          state_d = ST_FETCH;
        end else if (wr_valid && !swap_pending) begin
          mem_addr  = (wr_page ? PAGE_WORDS : '0) + wr_addr;
          mem_we    = 1'b1;
          mem_wdata = wr_data;
        end
      end
      ST_FETCH: begin
        mem_addr = base_q + ADDR_W'(k_q);
        k_d      = k_q + 1'b1;
        if (line_req) begin
          overrun_d = 1'b1;
        end
        if (k_q == K_LAST) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read data arrives a cycle after its address, so the line-buffer strobe trails by one.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      k_q          <= '0;
      overrun_q    <= 1'b0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
      fetch_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      k_q          <= k_d;
      overrun_q    <= overrun_d;
      lb_we_q      <= (state_q == ST_FETCH);
      lb_addr_q    <= k_q;
      fetch_done_q <= (state_q == ST_FETCH) && (k_q == K_LAST);
    end
  end

  assign lb_we      = lb_we_q;
  assign lb_addr    = lb_addr_q;
  assign lb_data    = mem_rdata;
  assign fetch_done = fetch_done_q;
  assign overrun    = overrun_q;
  assign disp_page  = disp_page_w;

endmodule

// File: tb/tb_fb_line_arbiter.sv
// Scoreboard bench for fb_line_arbiter: a transaction-level model predicts reads,
// writes, line-buffer strobes and status; a negedge monitor compares.
module tb_fb_line_arbiter;

  localparam int W     = 40;
  localparam int LINES = 480;
  localparam int PAGE  = W * LINES;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        line_req;
  logic [8:0]  line_idx;
  logic        frame_start;
  logic        fetch_done;
  logic        lb_we;
  logic [5:0]  lb_addr;
  logic [15:0] lb_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        wr_frame_done;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        overrun;
  logic        disp_page;

  fb_line_arbiter dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .line_req     (line_req),
    .line_idx     (line_idx),
    .frame_start  (frame_start),
    .fetch_done   (fetch_done),
    .lb_we        (lb_we),
    .lb_addr      (lb_addr),
    .lb_data      (lb_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_frame_done(wr_frame_done),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .overrun      (overrun),
    .disp_page    (disp_page)
  );

  always #10 clk_50 = ~clk_50;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t readQ[$];
  exp_t writeQ[$];
  exp_t lbQ[$];
  int   doneQ[$];

  int checks   = 0;
  int failures = 0;
  int cycleNo  = 0;
  int busyUntil = -1;
  bit started  = 1'b0;
  bit inReset  = 1'b1;
  bit dispCur, dispNxt, pendCur, pendNxt, ovrCur, ovrNxt, wrReadyExp;

  // Memories hold value XOR a per-address pattern so untouched words read back the pattern.
  bit [15:0] tbMem  [0:65535];
  bit [15:0] mdlMem [0:65535];

  function automatic logic [15:0] initWord(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  always @(posedge clk_50) begin
    cycleNo   <= cycleNo + 1;
    mem_rdata <= tbMem[mem_addr] ^ initWord(mem_addr);
    if (mem_we) tbMem[mem_addr] <= mem_wdata ^ initWord(mem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  task automatic reportMiss(input string name, input int cyc);
    checks++;
    failures++;
    $display("[TB] FAIL %s: event expected in cycle %0d never seen (now %0d)", name, cyc, cycleNo);
  endtask

  // One clock cycle of stimulus; the model predicts everything this cycle causes.
  task automatic applyStimulus(input logic lr, input logic [8:0] idx, input logic fs,
                               input logic wv, input logic [15:0] wa, input logic [15:0] wd,
                               input logic wfd);
    int now;
    int base;
    logic [15:0] a;
    @(posedge clk_50);
    #1;
    line_req = lr; line_idx = idx; frame_start = fs;
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_frame_done = wfd;
    dispCur = dispNxt; pendCur = pendNxt; ovrCur = ovrNxt;
    now = cycleNo;
    wrReadyExp = (now > busyUntil) && !lr && !pendCur;
    if (lr) begin
      if (now > busyUntil) begin
        base = (dispCur ? PAGE : 0) + int'(idx) * W;
        for (int k = 0; k < W; k++) begin
          a = 16'(base + k);
          readQ.push_back('{now + 1 + k, a, 16'h0});
          lbQ.push_back('{now + 2 + k, 16'(k), mdlMem[a] ^ initWord(a)});
        end
        doneQ.push_back(now + W + 1);
        busyUntil = now + W;
      end else begin
        ovrNxt = 1'b1;
      end
    end
    if (wv && wrReadyExp) begin
`ifdef FB_DOUBLE_BUFFER_EN
      a = 16'((dispCur ? 0 : PAGE) + int'(wa));
`else
      a = wa;
`endif
      writeQ.push_back('{now, a, wd});
      mdlMem[a] = wd ^ initWord(a);
    end
`ifdef FB_DOUBLE_BUFFER_EN
    if (fs && pendCur) begin
      dispNxt = !dispCur;
      pendNxt = wfd;
    end else if (wfd) begin
      pendNxt = 1'b1;
    end
`endif
  endtask

  task automatic doReset(input int n);
    @(posedge clk_50);
    #1;
    reset = 1'b1; inReset = 1'b1; started = 1'b1;
    line_req = 0; line_idx = 0; frame_start = 0; wr_valid = 0;
    wr_addr = 0; wr_data = 0; wr_frame_done = 0;
    readQ.delete(); writeQ.delete(); lbQ.delete(); doneQ.delete();
    busyUntil = -1;
    dispCur = 0; dispNxt = 0; pendCur = 0; pendNxt = 0; ovrCur = 0; ovrNxt = 0;
    repeat (n) @(posedge clk_50);
    #1;
    reset = 1'b0; inReset = 1'b0; wrReadyExp = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents an event.
  always @(negedge clk_50) begin
    exp_t e;
    int   d;
    if (started && inReset) begin
      checkOutput("rst_lb_we", lb_we, 0);
      checkOutput("rst_fetch_done", fetch_done, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_overrun", overrun, 0);
      checkOutput("rst_disp_page", disp_page, 0);
    end else if (started) begin
      checkOutput("wr_ready", wr_ready, wrReadyExp);
      checkOutput("overrun", overrun, ovrCur);
      checkOutput("disp_page", disp_page, dispCur);
      while (readQ.size() > 0 && readQ[0].cyc < cycleNo) reportMiss("mem_read", readQ.pop_front().cyc);
      if (readQ.size() > 0 && readQ[0].cyc == cycleNo) begin
        e = readQ.pop_front();
        checkOutput("rd_addr", mem_addr, e.addr);
        checkOutput("rd_we", mem_we, 0);
      end
      while (writeQ.size() > 0 && writeQ[0].cyc < cycleNo) reportMiss("mem_write", writeQ.pop_front().cyc);
      if (mem_we) begin
        if (writeQ.size() == 0) checkOutput("unexpected_write", 1, 0);
        else begin
          e = writeQ.pop_front();
          checkOutput("wr_cycle", cycleNo, e.cyc);
          checkOutput("wr_addr", mem_addr, e.addr);
          checkOutput("wr_data", mem_wdata, e.data);
        end
      end
      while (lbQ.size() > 0 && lbQ[0].cyc < cycleNo) reportMiss("lb_we", lbQ.pop_front().cyc);
      if (lb_we) begin
        if (lbQ.size() == 0) checkOutput("unexpected_lb_we", 1, 0);
        else begin
          e = lbQ.pop_front();
          checkOutput("lb_cycle", cycleNo, e.cyc);
          checkOutput("lb_addr", lb_addr, e.addr);
          checkOutput("lb_data", lb_data, e.data);
        end
      end
      while (doneQ.size() > 0 && doneQ[0] < cycleNo) reportMiss("fetch_done", doneQ.pop_front());
      if (fetch_done) begin
        if (doneQ.size() == 0) checkOutput("unexpected_fetch_done", 1, 0);
        else begin
          d = doneQ.pop_front();
          checkOutput("done_cycle", cycleNo, d);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    line_req = 0; line_idx = 0; frame_start = 0; wr_valid = 0;
    wr_addr = 0; wr_data = 0; wr_frame_done = 0;
    doReset(3);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] line 3 fetch with writer held off, second request mid-fetch");
    applyStimulus(1, 9'd3, 0, 1, 16'h10, 16'hBEEF, 0);
    for (int i = 1; i <= 45; i++) applyStimulus(i == 5, 9'd7, 0, 1, 16'h10, 16'hBEEF, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] frame done then frame start, then fetch of line 0");
    applyStimulus(0, 0, 0, 1, 16'h22, 16'h1234, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 16'h23, 16'h4321, 0);
    applyStimulus(0, 0, 1, 1, 16'h24, 16'h5555, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 16'h0, 16'hA0A0, 0);
    applyStimulus(1, 9'd0, 0, 0, 0, 0, 0);
    repeat (45) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] reset in the middle of a fetch");
    applyStimulus(1, 9'd10, 0, 0, 0, 0, 0);
    repeat (19) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    doReset(2);
    applyStimulus(1, 9'd10, 0, 0, 0, 0, 0);
    repeat (45) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      logic [8:0] idx;
      idx = ($urandom_range(0, 99) < 5) ? 9'($urandom_range(480, 511)) : 9'($urandom_range(0, 479));
      applyStimulus($urandom_range(0, 99) < 3, idx, $urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 70, 16'($urandom_range(0, PAGE - 1)),
                    16'($urandom), $urandom_range(0, 99) < 2);
    end
    repeat (50) applyStimulus(0, 0, 0, 0, 0, 0, 0);

    @(posedge clk_50);
    #1;
    started = 1'b0;
    while (readQ.size() > 0)  reportMiss("drain_read", readQ.pop_front().cyc);
    while (writeQ.size() > 0) reportMiss("drain_write", writeQ.pop_front().cyc);
    while (lbQ.size() > 0)    reportMiss("drain_lb", lbQ.pop_front().cyc);
    while (doneQ.size() > 0)  reportMiss("drain_done", doneQ.pop_front());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
